board_in: RTL

//  CPU-side reader for the DE2-115 board inputs key3_n..key1_n and sw[17:0].

---
 rtl/board_in.sv | 129 ++++++++++++
 1 files changed

// File: rtl/board_in.sv
// Board input reader: synchronizes and debounces the DE2-115 keys and switches,
// latches key presses as sticky pending bits and serves them over a small CPU register port.
module board_in #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key3_n,
  input  logic        key2_n,
  input  logic        key1_n,
  input  logic [17:0] sw,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq
);

  localparam int NIN = 21;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NIN-1:0]   raw;
  logic [NIN-1:0]   sync1;
  logic [NIN-1:0]   sync2;
  logic [NIN-1:0]   smp;
  logic [NIN-1:0]   db;
  logic [NIN-1:0]   db_next;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [2:0]       pend;
  logic [2:0]       pend_next;
  logic [2:0]       rise;
  logic [2:0]       clr;
  logic             ie;
  logic             access;
  logic             wr_status;
  logic [31:0]      rd_val;
  logic             unused_bits;

  // Bits [2:0] are the keys (made active high), bits [20:3] the switches.
  assign raw = {sw, ~key3_n, ~key2_n, ~key1_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

  // A bit is accepted only when the current sample matches the one from the previous tick.
  always_comb begin
    db_next = db;
    if (tick) begin
      db_next = (db & (sync2 ^ smp)) | (sync2 & ~(sync2 ^ smp));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp <= '0;
      db  <= '0;
    end else begin
      if (tick) begin
        smp <= sync2;
      end
      db <= db_next;
    end
  end

  assign access    = stb & ~ack;
  assign wr_status = access & we & (addr == 2'd0);
  assign clr       = wr_status ? data_in[2:0] : 3'b000;
  assign rise      = db_next[2:0] & ~db[2:0];
  assign pend_next = (pend & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      ie   <= 1'b0;
    end else begin
      pend <= pend_next;
      if (wr_status) begin
        ie <= data_in[8];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      2'd0:    rd_val = {13'b0, db[2:0], 7'b0, ie, 5'b0, pend};
      2'd1:    rd_val = {14'b0, db[20:3]};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= 1'b0;
      data_out <= '0;
    end else begin
      ack      <= access;
      data_out <= (access && !we) ? rd_val : 32'd0;
    end
  end

  assign irq = ie & (|pend);

  assign unused_bits = ^{data_in[31:9], data_in[7:3]};

endmodule
